// File: rtl/kronos_types.sv
// Shared Kronos platform types: owner encoding for the SRAM arbiter and word geometry.
package kronos_types;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } arb_owner_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/kronos_arb_pick.sv
// Two-way request picker (bit 0 = instruction, bit 1 = data) returning a one-hot grant.
// KRONOS_ARB_RR_EN selects round-robin tie breaking; otherwise data wins every tie.
module kronos_arb_pick (
  input  logic [1:0] req_i,
`ifdef KRONOS_ARB_RR_EN
  input  logic       last_data_i,
`endif
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
`ifdef KRONOS_ARB_RR_EN
      // Tie goes to whichever port was not served last.
      gnt_o = last_data_i ? 2'b01 : 2'b10;
`else
      gnt_o = 2'b10;
`endif
    end
  end

endmodule

// File: rtl/kronos_mem_arbiter.sv
// Shares the single-port SRAM between the Kronos fetch and load/store ports, one access per cycle.
// Define KRONOS_ARB_RR_EN for round-robin ties; default build uses fixed data-first priority.
module kronos_mem_arbiter
  import kronos_types::*;
#(
  parameter  int MEM_DEPTH = 1024,
  localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_addr,
  input  logic              instr_req,
  output logic              instr_gnt,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_mask,
  input  logic              data_wr_en,
  input  logic              data_req,
  output logic              data_gnt,
  output logic              data_ack,
  output logic [31:0]       data_rd_data,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [3:0]        mem_mask,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  logic [1:0]  pick_gnt;
  logic        instr_inr;
  logic        data_inr;
  logic        data_store;
  logic        unused_addr_bits;

  arb_owner_e  owner_q, owner_d;
  logic        oor_q, oor_d;
  logic        store_q, store_d;
`ifdef KRONOS_ARB_RR_EN
  logic        last_data_q, last_data_d;
`endif

  kronos_arb_pick u_pick (
    .req_i       ({data_req, instr_req}),
`ifdef KRONOS_ARB_RR_EN
    .last_data_i (last_data_q),
`endif
    .gnt_o       (pick_gnt)
  );

  // Grant cycle: arbitration and SRAM access issue are purely combinational.
  assign instr_gnt = pick_gnt[0] & ~rst;
  assign data_gnt  = pick_gnt[1] & ~rst;

  assign instr_inr = (instr_addr[31:MEM_AW+OFF_W] == '0);
  assign data_inr  = (data_addr[31:MEM_AW+OFF_W] == '0);

  assign data_store  = data_gnt & data_inr & data_wr_en;
  assign mem_en      = (instr_gnt & instr_inr) | (data_gnt & data_inr);
  assign mem_wr_en   = data_store & (|data_mask);
  assign mem_mask    = data_store ? data_mask : 4'b0000;
  assign mem_wr_data = data_store ? data_wr_data : 32'd0;
  assign mem_addr    = data_gnt  ? data_addr[MEM_AW+OFF_W-1:OFF_W] :
                       instr_gnt ? instr_addr[MEM_AW+OFF_W-1:OFF_W] : '0;

  assign unused_addr_bits = ^{instr_addr[OFF_W-1:0], data_addr[OFF_W-1:0]};

  always_comb begin
    owner_d = OWNER_NONE;
    oor_d   = 1'b0;
    store_d = 1'b0;
    if (data_gnt) begin
      owner_d = OWNER_DATA;
      oor_d   = ~data_inr;
      store_d = data_wr_en;
    end else if (instr_gnt) begin
      owner_d = OWNER_INSTR;
      oor_d   = ~instr_inr;
    end
`ifdef KRONOS_ARB_RR_EN
    last_data_d = last_data_q;
    if (data_gnt) begin
      last_data_d = 1'b1;
    end else if (instr_gnt) begin
      last_data_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWNER_NONE;
      oor_q       <= 1'b0;
      store_q     <= 1'b0;
`ifdef KRONOS_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      owner_q     <= owner_d;
      oor_q       <= oor_d;
      store_q     <= store_d;
`ifdef KRONOS_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Ack cycle: a reset arriving here discards the in-flight response.
  assign instr_ack    = (owner_q == OWNER_INSTR) & ~rst;
  assign data_ack     = (owner_q == OWNER_DATA) & ~rst;
  assign instr_data   = (instr_ack & ~oor_q) ? mem_rd_data : 32'd0;
  assign data_rd_data = (data_ack & ~oor_q & ~store_q) ? mem_rd_data : 32'd0;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Scoreboard bench for kronos_mem_arbiter: directed requests push expected acks, a monitor pops them.
module tb_kronos_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr, data_addr, data_wr_data;
  logic        instr_req, data_req, data_wr_en;
  logic [3:0]  data_mask;
  logic        instr_gnt, instr_ack, data_gnt, data_ack;
  logic [31:0] instr_data, data_rd_data;
  logic        mem_en, mem_wr_en;
  logic [3:0]  mem_mask;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = 32'd0;

  logic [31:0] mem [0:1023];

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  kronos_mem_arbiter #(.MEM_DEPTH(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_gnt    (instr_gnt),
    .instr_ack    (instr_ack),
    .instr_data   (instr_data),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_gnt     (data_gnt),
    .data_ack     (data_ack),
    .data_rd_data (data_rd_data),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_mask     (mem_mask),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read-before-write, data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr][8*b +: 8] = mem_wr_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest expectation and arrive one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (instr_ack && data_ack) chk("both_acks", 32'd1, 32'd0);
    if (instr_ack || data_ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {31'd0, data_ack}, {31'd0, instr_ack});
      end else begin
        e = q.pop_front();
        chk("ack_port", {31'd0, data_ack}, {31'd0, e.is_data});
        chk("ack_data", data_ack ? data_rd_data : instr_data, e.data);
        chk("ack_latency", cyc, e.cyc + 1);
      end
    end
    if (!instr_ack) chk("instr_data_idle", instr_data, 32'd0);
    if (!data_ack)  chk("data_rd_data_idle", data_rd_data, 32'd0);
  end

  task automatic set_idle();
    instr_req = 1'b0;
    data_req  = 1'b0;
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic issue(input bit is_data, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] mask, input bit we, input logic [31:0] exp_data,
                       input bit exp_en, input logic [9:0] exp_maddr, input bit exp_we,
                       input bit push);
    exp_t e;
    instr_req = !is_data;
    data_req  = is_data;
    if (is_data) begin
      data_addr = addr; data_wr_data = wd; data_mask = mask; data_wr_en = we;
    end else begin
      instr_addr = addr;
    end
    @(negedge clk);
    chk("instr_gnt", {31'd0, instr_gnt}, {31'd0, !is_data});
    chk("data_gnt", {31'd0, data_gnt}, {31'd0, is_data});
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
    if (exp_en) chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_maddr});
    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_we});
    if (exp_we) chk("mem_mask", {28'd0, mem_mask}, {28'd0, mask});
    if (push) begin
      e.is_data = is_data; e.data = exp_data; e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   exp_d;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + i;
    mem[32'h10]  = 32'hDEADBEEF;
    mem[32'h101] = 32'd0;

    // Reset with both ports requesting: nothing may be granted or issued.
    rst = 1'b1;
    instr_req = 1'b1; data_req = 1'b1;
    instr_addr = 32'h40; data_addr = 32'h404;
    data_wr_data = 32'd0; data_mask = 4'd0; data_wr_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_instr_gnt", {31'd0, instr_gnt}, 32'd0);
      chk("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);

    // Isolated fetch.
    issue(0, 32'h40, 0, 0, 0, 32'hDEADBEEF, 1, 10'h10, 0, 1);
    idle_cycles(2);

    // Byte store then load of the same word.
    issue(1, 32'h404, 32'h11223344, 4'b0100, 1, 32'd0, 1, 10'h101, 1, 1);
    issue(1, 32'h404, 0, 4'b0000, 0, 32'h00220000, 1, 10'h101, 0, 1);
    // Store with empty mask is acked but does not write.
    issue(1, 32'h404, 32'hFFFFFFFF, 4'b0000, 1, 32'd0, 1, 10'h101, 0, 1);
    issue(1, 32'h404, 0, 4'b0000, 0, 32'h00220000, 1, 10'h101, 0, 1);
    idle_cycles(2);

    // Eight back-to-back fetches.
    for (int i = 0; i < 8; i++)
      issue(0, 4 * i, 0, 0, 0, 32'hA000_0000 + i, 1, i[9:0], 0, 1);
    idle_cycles(2);

    // Out-of-range load and fetch: granted, no SRAM access, zero data.
    issue(1, 32'h0000_1000, 0, 0, 0, 32'd0, 0, 10'h0, 0, 1);
    issue(1, 32'h0000_1000, 32'h12345678, 4'hF, 1, 32'd0, 0, 10'h0, 0, 1);
    issue(0, 32'h8000_0040, 0, 0, 0, 32'd0, 0, 10'h0, 0, 1);
    idle_cycles(2);

    // Contention for six cycles; the last grant above went to instr.
    instr_addr = 32'h40; data_addr = 32'h404; data_wr_en = 1'b0; data_mask = 4'd0;
    instr_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef KRONOS_ARB_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      @(negedge clk);
      chk("tie_data_gnt", {31'd0, data_gnt}, {31'd0, exp_d});
      chk("tie_instr_gnt", {31'd0, instr_gnt}, {31'd0, !exp_d});
      e.is_data = exp_d;
      e.data    = exp_d ? 32'h00220000 : 32'hDEADBEEF;
      e.cyc     = cyc;
      q.push_back(e);
      @(posedge clk); #1;
    end
    idle_cycles(2);

    // Reset in the ack cycle of a load: the ack is dropped.
    issue(1, 32'h404, 0, 0, 0, 32'd0, 1, 10'h101, 0, 0);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    chk("rst_mid_data_ack", {31'd0, data_ack}, 32'd0);
    chk("rst_mid_rd_data", data_rd_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_after_acks", {30'd0, instr_ack, data_ack}, 32'd0);
    chk("rst_after_mem", {27'd0, mem_en, mem_wr_en, mem_mask[2:0]}, 32'd0);
    chk("rst_after_data", instr_data | data_rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    instr_req = 1'b1; data_req = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_data", {31'd0, data_gnt}, 32'd1);
    chk("post_rst_tie_instr", {31'd0, instr_gnt}, 32'd0);
    e.is_data = 1'b1; e.data = 32'h00220000; e.cyc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    idle_cycles(3);

    chk("missing_acks", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
